// File: rtl/enemy_director.sv
// Frame-rate director for the four playfield enemies: staggered spawns, respawn after squash,
// single chef_hit event with a global freeze, and restart of the spawn sequence.
module enemy_director #(
  parameter int unsigned SPAWN_INTERVAL = 120,
  parameter int unsigned RESPAWN_DELAY  = 180,
  parameter int unsigned FREEZE_FRAMES  = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       level_done,
  input  logic [3:0] slot_hit,
  input  logic [3:0] slot_squashed,
  output logic [3:0] slot_active,
  output logic [3:0] slot_reset,
  output logic [3:0] slot_side,
  output logic       freeze,
  output logic       chef_hit,
  output logic [2:0] dir_state,
  output logic [2:0] alive_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STAGGER = 3'd1,
    S_RUN     = 3'd2,
    S_FREEZE  = 3'd3,
    S_DONE    = 3'd4
  } dir_state_t;

  typedef enum logic [1:0] {
    SL_INACTIVE = 2'd0,
    SL_ACTIVE   = 2'd1,
    SL_WAIT     = 2'd2
  } slot_state_t;

  localparam logic [8:0] SPAWN_LOAD   = 9'(SPAWN_INTERVAL);
  localparam logic [8:0] RESPAWN_LOAD = 9'(RESPAWN_DELAY);
  localparam logic [8:0] FREEZE_LOAD  = 9'(FREEZE_FRAMES);

  dir_state_t  r_state, w_state_next;
  logic [8:0]  r_cnt;            // stagger interval in STAGGER, hold time in FREEZE
  logic [1:0]  r_spawn_idx;
  logic        r_side;
  slot_state_t r_slot_st  [4];
  logic [8:0]  r_slot_tmr [4];
  logic [3:0]  r_slot_active, r_slot_reset, r_slot_side;
  logic        r_chef_hit;
  logic [2:0]  r_alive_count;

  logic       w_hit, w_cnt_expire;
  logic       w_restart, w_clear, w_hit_take, w_slots_run, w_stagger_spawn;
  logic [3:0] w_spawn_mask, w_squash_mask, w_side_bits;
  logic       w_side_tog;

  assign w_hit        = |(slot_hit & r_slot_active);
  assign w_cnt_expire = (r_cnt == 9'd1);

  // NOTE: state register only holds state; all decisions live in the always_comb below.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Priority inside each live state: level_done, then hit, then squash/spawn.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_state_next    = r_state;
    w_restart       = 1'b0;
    w_clear         = 1'b0;
    w_hit_take      = 1'b0;
    w_slots_run     = 1'b0;
    w_stagger_spawn = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (game_start) begin
          w_state_next = S_STAGGER;
          w_restart    = 1'b1;
        end
      end
      S_STAGGER, S_RUN: begin
        if (level_done) begin
          w_state_next = S_DONE;
          w_clear      = 1'b1;
        end else if (w_hit) begin
          w_state_next = S_FREEZE;
          w_hit_take   = 1'b1;
        end else begin
          w_slots_run = 1'b1;
          if (r_state == S_STAGGER && w_cnt_expire) begin
            w_stagger_spawn = 1'b1;
            if (r_spawn_idx == 2'd3) w_state_next = S_RUN;
          end
        end
      end
      S_FREEZE: begin
        if (level_done) begin
          w_state_next = S_DONE;
          w_clear      = 1'b1;
        end else if (w_cnt_expire) begin
          if (game_over) begin
            w_state_next = S_DONE;
            w_clear      = 1'b1;
          end else begin
            w_state_next = S_STAGGER;
            w_restart    = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_spawn_mask  = '0;
    w_squash_mask = '0;
    if (w_restart)       w_spawn_mask[0]           = 1'b1;
    if (w_stagger_spawn) w_spawn_mask[r_spawn_idx] = 1'b1;
    if (w_slots_run) begin
      for (int i = 0; i < 4; i++) begin
        if (r_slot_st[i] == SL_WAIT && r_slot_tmr[i] <= 9'd1) w_spawn_mask[i]  = 1'b1;
        if (r_slot_st[i] == SL_ACTIVE && slot_squashed[i])    w_squash_mask[i] = 1'b1;
      end
    end
  end

  // Several spawns in one frame take the side toggle in ascending slot order.
  always_comb begin
    w_side_bits = r_slot_side;
    w_side_tog  = r_side;
    for (int i = 0; i < 4; i++) begin
      if (w_spawn_mask[i]) begin
        w_side_bits[i] = w_side_tog;
        w_side_tog     = ~w_side_tog;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_cnt         <= '0;
      r_spawn_idx   <= '0;
      r_side        <= 1'b0;
      r_slot_active <= '0;
      r_slot_reset  <= '0;
      r_slot_side   <= '0;
      r_chef_hit    <= 1'b0;
      r_alive_count <= '0;
      // NOTE: the per-slot arrays are four flop sets, not a RAM, so they are reset like any register.
      for (int i = 0; i < 4; i++) begin
        r_slot_st[i]  <= SL_INACTIVE;
        r_slot_tmr[i] <= '0;
      end
    end else begin
      r_chef_hit    <= w_hit_take;
      r_slot_reset  <= w_spawn_mask;
      r_slot_side   <= w_side_bits;
      r_side        <= w_side_tog;
      r_alive_count <= {2'b0, r_slot_active[0]} + {2'b0, r_slot_active[1]}
                     + {2'b0, r_slot_active[2]} + {2'b0, r_slot_active[3]};

      if (w_restart)            r_cnt <= SPAWN_LOAD;
      else if (w_hit_take)      r_cnt <= FREEZE_LOAD;
      else if (w_clear)         r_cnt <= '0;
      else if (w_stagger_spawn) r_cnt <= (r_spawn_idx == 2'd3) ? 9'd0 : SPAWN_LOAD;
      else if ((r_state == S_STAGGER && w_slots_run) || r_state == S_FREEZE)
        r_cnt <= r_cnt - 9'd1;

      if (w_restart || w_clear) begin
        r_spawn_idx   <= w_restart ? 2'd1 : 2'd0;
        r_slot_active <= w_spawn_mask;
        for (int i = 0; i < 4; i++) begin
          r_slot_st[i]  <= w_spawn_mask[i] ? SL_ACTIVE : SL_INACTIVE;
          r_slot_tmr[i] <= '0;
        end
      end else begin
        if (w_stagger_spawn) r_spawn_idx <= r_spawn_idx + 2'd1;
        for (int i = 0; i < 4; i++) begin
          if (w_spawn_mask[i]) begin
            r_slot_active[i] <= 1'b1;
            r_slot_st[i]     <= SL_ACTIVE;
            r_slot_tmr[i]    <= '0;
          end else if (w_squash_mask[i]) begin
            r_slot_active[i] <= 1'b0;
            r_slot_st[i]     <= SL_WAIT;
            r_slot_tmr[i]    <= RESPAWN_LOAD;
          end else if (w_slots_run && r_slot_st[i] == SL_WAIT) begin
            r_slot_tmr[i] <= r_slot_tmr[i] - 9'd1;
          end
        end
      end
    end
  end

  assign slot_active = r_slot_active;
  assign slot_reset  = r_slot_reset;
  assign slot_side   = r_slot_side;
  assign freeze      = (r_state == S_FREEZE) || (r_state == S_DONE);
  assign chef_hit    = r_chef_hit;
  assign dir_state   = r_state;
  assign alive_count = r_alive_count;

endmodule

// File: tb/tb_enemy_director.sv
// Scoreboard bench for enemy_director: a frame-level behavioural model predicts every output
// frame; a monitor compares the DUT against the queued predictions.
module tb_enemy_director;

  localparam int SI = 4;
  localparam int RD = 5;
  localparam int FF = 3;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       game_start = 1'b0, game_over = 1'b0, level_done = 1'b0;
  logic [3:0] slot_hit = '0, slot_squashed = '0;
  logic [3:0] slot_active, slot_reset, slot_side;
  logic       freeze, chef_hit;
  logic [2:0] dir_state, alive_count;

  enemy_director #(.SPAWN_INTERVAL(SI), .RESPAWN_DELAY(RD), .FREEZE_FRAMES(FF)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_start(game_start), .game_over(game_over),
    .level_done(level_done), .slot_hit(slot_hit), .slot_squashed(slot_squashed),
    .slot_active(slot_active), .slot_reset(slot_reset), .slot_side(slot_side),
    .freeze(freeze), .chef_hit(chef_hit), .dir_state(dir_state), .alive_count(alive_count)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [3:0] active, rst, side;
    logic       frz, chef;
    logic [2:0] st, alive;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 stagger, 2 run, 3 freeze, 4 done.
  int m_mode, m_cnt, m_next;
  bit m_tog;
  bit m_act[4], m_side[4], m_rst[4];
  int m_wait[4];
  bit m_chef;

  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_next = 0; m_tog = 0; m_chef = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0; m_side[i] = 0; m_rst[i] = 0; m_wait[i] = 0;
    end
  endfunction

  function automatic void spawn(int i);
    m_act[i] = 1; m_wait[i] = 0; m_rst[i] = 1;
    m_side[i] = m_tog; m_tog = ~m_tog;
  endfunction

  function automatic void clear_slots();
    for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_wait[i] = 0; end
  endfunction

  function automatic void begin_level();
    clear_slots();
    m_mode = 1; m_next = 1; m_cnt = SI;
    spawn(0);
  endfunction

  function automatic void goto_done();
    clear_slots();
    m_mode = 4;
  endfunction

  function automatic exp_t model_step(bit start, bit over, bit done, logic [3:0] hit, logic [3:0] sq);
    exp_t e;
    int   pop;
    bit   any_hit;
    bit   due[4];
    pop = 0; any_hit = 0;
    for (int i = 0; i < 4; i++) begin
      pop += int'(m_act[i]);
      if (hit[i] && m_act[i]) any_hit = 1;
      m_rst[i] = 0; due[i] = 0;
    end
    m_chef = 0;
    case (m_mode)
      0, 4: if (start) begin_level();
      1, 2: begin
        if (done) goto_done();
        else if (any_hit) begin m_chef = 1; m_mode = 3; m_cnt = FF; end
        else begin
          for (int i = 0; i < 4; i++)
            if (m_wait[i] > 0) begin m_wait[i]--; if (m_wait[i] == 0) due[i] = 1; end
          for (int i = 0; i < 4; i++)
            if (m_act[i] && sq[i]) begin m_act[i] = 0; m_wait[i] = RD; end
          if (m_mode == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
              due[m_next] = 1;
              if (m_next == 3) m_mode = 2;
              else begin m_next++; m_cnt = SI; end
            end
          end
          for (int i = 0; i < 4; i++) if (due[i]) spawn(i);
        end
      end
      3: begin
        if (done) goto_done();
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (over) goto_done();
            else begin_level();
          end
        end
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      e.active[i] = m_act[i]; e.rst[i] = m_rst[i]; e.side[i] = m_side[i];
    end
    e.frz   = (m_mode == 3 || m_mode == 4);
    e.chef  = m_chef;
    e.st    = 3'(m_mode);
    e.alive = 3'(pop);
    return e;
  endfunction

  // Monitor: one prediction per clock edge while the bench is driving.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("slot_active", 32'(slot_active), 32'(e.active));
        check("slot_reset",  32'(slot_reset),  32'(e.rst));
        check("slot_side",   32'(slot_side),   32'(e.side));
        check("freeze",      32'(freeze),      32'(e.frz));
        check("chef_hit",    32'(chef_hit),    32'(e.chef));
        check("dir_state",   32'(dir_state),   32'(e.st));
        check("alive_count", 32'(alive_count), 32'(e.alive));
      end
    end
  end

  task automatic drive(bit st, bit ov, bit dn, logic [3:0] h, logic [3:0] s);
    @(negedge frame_clk);
    game_start = st; game_over = ov; level_done = dn; slot_hit = h; slot_squashed = s;
    sb_q.push_back(model_step(st, ov, dn, h, s));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 4'b0000, 4'b0000);
  endtask

  task automatic release_reset();
    @(negedge frame_clk);
    Reset = 1'b0;
    sb_q.push_back(model_step(0, 0, 0, 4'b0000, 4'b0000));
  endtask

  // Reset in mid-frame: outputs must clear before any clock edge.
  task automatic mid_reset();
    @(negedge frame_clk);
    game_start = 0; game_over = 0; level_done = 0; slot_hit = '0; slot_squashed = '0;
    #2 Reset = 1'b1;
    #1;
    check("async_rst_active", 32'(slot_active), 32'd0);
    check("async_rst_reset",  32'(slot_reset),  32'd0);
    check("async_rst_side",   32'(slot_side),   32'd0);
    check("async_rst_freeze", 32'(freeze),      32'd0);
    check("async_rst_chef",   32'(chef_hit),    32'd0);
    check("async_rst_state",  32'(dir_state),   32'd0);
    check("async_rst_alive",  32'(alive_count), 32'd0);
    model_reset();
    release_reset();
  endtask

  initial begin
    logic       st, ov, dn;
    logic [3:0] h, s;
    model_reset();
    #3;
    check("reset_state",  32'(dir_state),   32'd0);
    check("reset_active", 32'(slot_active), 32'd0);
    check("reset_freeze", 32'(freeze),      32'd0);
    check("reset_alive",  32'(alive_count), 32'd0);
    repeat (2) @(posedge frame_clk);
    release_reset();

    // Staggered start, then a two-frame multi-slot hit with restart after the freeze.
    drive(1, 0, 0, 4'b0000, 4'b0000); idle(14);
    drive(0, 0, 0, 4'b0110, 4'b0000); drive(0, 0, 0, 4'b0110, 4'b0000); idle(17);
    // Squash and respawn of slot 2.
    drive(0, 0, 0, 4'b0000, 4'b0100); idle(7);
    // Hit and squash on the same slot in the same frame.
    drive(0, 0, 0, 4'b0010, 4'b0010); idle(8);
    // level_done mid-stagger, then restart from DONE.
    drive(0, 0, 1, 4'b0000, 4'b0000); idle(2);
    drive(1, 0, 0, 4'b0000, 4'b0000); idle(14);
    // Hit with game_over held: DONE at freeze expiry.
    drive(0, 1, 0, 4'b0001, 4'b0000);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 4'b0000, 4'b0000);
    drive(1, 0, 0, 4'b0000, 4'b0000); idle(16);
    mid_reset();

    ov = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500 || $urandom_range(0, 999) == 0) mid_reset();
      st = ($urandom_range(0, 7) == 0);
      dn = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 63) == 0) ov = ~ov;
      for (int b = 0; b < 4; b++) begin
        h[b] = ($urandom_range(0, 39) == 0);
        s[b] = ($urandom_range(0, 11) == 0);
      end
      drive(st, ov, dn, h, s);
    end

    @(negedge frame_clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/enemy_director.md
Name: enemy_director

Overview:
- Frame-rate controller that sequences the four enemy instances in the playfield.
- Staggers the enemy spawns at level start and collapses their per-enemy chef-contact flags into one chef_hit event.
- Freezes all enemies after a hit, then restarts the spawn sequence.
- Respawns squashed enemies after a delay.
- Sits between the enemy datapaths (which own position/motion) and the top-level game FSM (lives, score).

Parameters:
- SPAWN_INTERVAL, 120, frames between successive slot spawns during staggered start; legal range 1..511.
- RESPAWN_DELAY, 180, frames a squashed slot stays inactive before respawn; legal range 1..511.
- FREEZE_FRAMES, 60, frames all enemies are held after chef hit; legal range 1..511.

Ports:
- frame_clk  in  1  frame clock; all logic on posedge.
- Reset  in  1  reset; asynchronous, active-high.
- game_start  in  1  one-frame pulse; starts or restarts the level from IDLE or DONE.
- game_over  in  1  level from game FSM; sampled only at FREEZE expiry.
- level_done  in  1  level; all burgers complete.
- slot_hit  in  4  per-slot enemy_hurt (chef contact), level.
- slot_squashed  in  4  per-slot squash pulse from burger logic.
- slot_active  out  4  slot enable; an enemy is drawn and moves only when set.
- slot_reset  out  4  one-frame pulse to re-centre the enemy datapath; drive it ORed into that enemy's Reset.
- slot_side  out  4  spawn side latched at each spawn: 0 = left, 1 = right.
- freeze  out  1  hold all enemy motion.
- chef_hit  out  1  one-frame pulse per hit event.
- dir_state  out  3  encoded FSM state for debug/HUD.
- alive_count  out  3  population count of slot_active, registered.

Behaviour:
- Reset values:
  - All outputs 0; dir_state = IDLE.
  - All counters 0, spawn index 0, side toggle 0, all per-slot states INACTIVE.
- Global FSM (encoding: IDLE=0, STAGGER=1, RUN=2, FREEZE=3, DONE=4):
  - IDLE: on game_start -> STAGGER. On that same edge, spawn slot 0 and load the spawn counter with SPAWN_INTERVAL.
  - STAGGER: spawn counter decrements each frame. On reaching 0:
    - spawn the next index and reload the counter;
    - after slot 3 is spawned -> RUN.
  - RUN: steady state; per-slot respawn logic is active.
  - FREEZE: freeze=1; slot_active is unchanged; counter loaded with FREEZE_FRAMES on entry. At expiry:
    - if game_over=1 -> DONE;
    - else clear all slot_active and per-slot timers, set spawn index 0, spawn slot 0, -> STAGGER.
  - DONE: freeze=1, slot_active=0. game_start -> STAGGER (same entry action as from IDLE).
- A spawn of slot i, as one registered edge:
  - slot_active[i] <= 1 and slot_reset[i] <= 1 for exactly one frame;
  - slot_side[i] <= side toggle, then the side toggle inverts.
- Hit handling, in STAGGER or RUN:
  - Any bit of (slot_hit & slot_active) high -> chef_hit=1 for one frame, -> FREEZE.
  - Multiple simultaneous hits produce a single pulse.
  - slot_hit is ignored in IDLE, FREEZE and DONE.
- Per-slot state (INACTIVE/ACTIVE/WAIT) with a 9-bit timer, in STAGGER and RUN:
  - ACTIVE and slot_squashed[i] -> slot_active[i] <= 0, timer <= RESPAWN_DELAY, WAIT.
  - WAIT: the timer decrements each frame. At 0, respawn the slot (spawn action above), -> ACTIVE.
  - In STAGGER, a slot not yet spawned ignores squash.
  - Squash of an INACTIVE or WAIT slot is ignored.
  - Per-slot timers are held (not decremented) during FREEZE.
- Simultaneous-event priority, same frame:
  - level_done > hit > squash > spawn/respawn.
  - A hit and a squash on the same slot in the same frame count as a hit: freeze is entered, and the slot stays active.
- level_done in STAGGER, RUN or FREEZE -> DONE next edge; outputs follow DONE values.
- game_start is ignored in STAGGER, RUN and FREEZE.
- slot_reset is only ever a single-frame pulse; it is 0 in all frames other than a spawn edge.
- alive_count lags slot_active by one frame.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous) and aborts any pending spawn.

Test Plan:
1. SPAWN_INTERVAL=4. Reset, then game_start pulse.
   -> slot_reset = 0001, 0010, 0100, 1000 on frames 1, 5, 9, 13.
   -> slot_side = 0, 1, 0, 1.
   -> dir_state = 2 at frame 13; alive_count = 4 at frame 14.
2. RUN, FREEZE_FRAMES=3, game_over=0. Raise slot_hit = 0110 for 2 frames.
   -> Exactly one chef_hit pulse; freeze=1 for 3 frames.
   -> slot_active then drops to 0000; slot 0 respawns (slot_reset=0001); dir_state=1.
3. RUN, RESPAWN_DELAY=5. slot_squashed[2] pulse.
   -> slot_active=1011 next frame.
   -> slot_reset=0100 and slot_active=1111 exactly 5 frames later.
4. Same frame: slot_hit[1]=1 and slot_squashed[1]=1.
   -> chef_hit pulse, FREEZE, slot_active[1] stays 1, no WAIT entered.
5. Mid-STAGGER (two slots spawned): level_done=1.
   -> dir_state=4, freeze=1, slot_active=0000.
   -> A later game_start restarts with slot_reset=0001.
6. In FREEZE with game_over=1 -> DONE at expiry. Assert Reset mid-RUN -> all outputs 0 without waiting for a clock edge.
